// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus responder: FSM states, word width
// and the address error check used when a request reaches its response.
package mem_bus_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // A request is in error when it is not word aligned or falls past the storage.
  function automatic logic addr_err(input logic [31:0] adr, input int unsigned depth);
    return (adr[1:0] != 2'b00) || ({2'b00, adr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module word_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_bus_responder.sv
// Data-memory bus responder: accepts one request, waits WAIT_STATES cycles,
// then answers with a one-cycle ack carrying read data and an error flag.
module dmem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              memwrite,
  input  logic [31:0]       dataadr,
  input  logic [WORD_W-1:0] writedata,
  output logic              ack,
  output logic [WORD_W-1:0] readdata,
  output logic              err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_write;
  logic [31:0]       cap_adr;
  logic [WORD_W-1:0] cap_wdata;

  logic              eff_write;
  logic [31:0]       eff_adr;
  logic [WORD_W-1:0] eff_wdata;
  logic              go_resp;
  logic              eff_err;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  // With no wait states the commit edge is the accept edge, so the live inputs
  // stand in for the not-yet-captured request.
  always_comb begin
    eff_write = cap_write;
    eff_adr   = cap_adr;
    eff_wdata = cap_wdata;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        eff_write = memwrite;
        eff_adr   = dataadr;
        eff_wdata = writedata;
        go_resp   = req && (WAIT_STATES == 0);
      end
      WAIT:    go_resp = (cnt == WS_LAST);
      default: go_resp = 1'b0;
    endcase
  end

  assign eff_err = addr_err(eff_adr, DEPTH_WORDS);
  assign ram_we  = go_resp && eff_write && !eff_err && !reset;

  word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (eff_adr[AW+1:2]),
    .wdata(eff_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_adr   <= '0;
      cap_wdata <= '0;
      ack       <= 1'b0;
      readdata  <= '0;
      err       <= 1'b0;
    end else begin
      ack      <= 1'b0;
      readdata <= '0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cap_write <= memwrite;
            cap_adr   <= dataadr;
            cap_wdata <= writedata;
            cnt       <= 4'd0;
            state     <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (cnt == WS_LAST) state <= RESP;
          else                cnt   <= cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        ack      <= 1'b1;
        err      <= eff_err;
        readdata <= (!eff_write && !eff_err) ? ram_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Bench for dmem_bus_responder: one instance with two wait states and one with
// none, driven by directed and random transactions against an array model.
module tb_dmem_bus_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_a, mw_a, ack_a, err_a;
  logic [31:0] adr_a, wd_a, rd_a;
  logic        req_b, mw_b, ack_b, err_b;
  logic [31:0] adr_b, wd_b, rd_b;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [DEPTH];

  dmem_bus_responder #(.WAIT_STATES(WS), .DEPTH_WORDS(DEPTH)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .memwrite(mw_a), .dataadr(adr_a),
    .writedata(wd_a), .ack(ack_a), .readdata(rd_a), .err(err_a)
  );

  dmem_bus_responder #(.WAIT_STATES(0), .DEPTH_WORDS(DEPTH)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .memwrite(mw_b), .dataadr(adr_b),
    .writedata(wd_b), .ack(ack_b), .readdata(rd_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_adr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, DEPTH - 1) * 4);
      2:       return 32'($urandom_range(0, 4 * DEPTH + 15));
      default: return $urandom;
    endcase
  endfunction

  // One transaction on the two-wait-state instance; the request fields are
  // scrambled after acceptance to show the captured copy is what answers.
  task automatic txn_a(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int          k;
    logic        e;
    logic [31:0] er;
    e  = exp_err(a);
    er = 32'h0;
    if (!wr && !e) er = model[a / 4];
    req_a = 1'b1; mw_a = wr; adr_a = a; wd_a = d;
    step();
    mw_a = 1'($urandom); adr_a = $urandom; wd_a = $urandom;
    k = 0;
    while (!ack_a && k < 20) begin
      check("idle_rd", rd_a, 32'h0);
      check("idle_err", {31'h0, err_a}, 32'h0);
      step();
      k++;
    end
    req_a = 1'b0;
    check("latency", 32'(k), 32'(WS));
    check("resp_err", {31'h0, err_a}, {31'h0, e});
    check("resp_rd", rd_a, er);
    if (wr && !e) model[a / 4] = d;
    step();
    check("ack_one_cycle", {31'h0, ack_a}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; mw_a = 1'b0; adr_a = '0; wd_a = '0;
    req_b = 1'b0; mw_b = 1'b0; adr_b = '0; wd_b = '0;
    step(); step(); step();
    check("rst_ack_a", {31'h0, ack_a}, 32'h0);
    check("rst_err_a", {31'h0, err_a}, 32'h0);
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_ack_b", {31'h0, ack_b}, 32'h0);
    check("rst_err_b", {31'h0, err_b}, 32'h0);
    check("rst_rd_b", rd_b, 32'h0);
    reset = 1'b0;
    step();

    for (int w = 0; w < DEPTH; w++) txn_a(1'b1, 32'(w * 4), $urandom);

    txn_a(1'b1, 32'h10, 32'hDEADBEEF);
    txn_a(1'b0, 32'h10, 32'h0);
    check("deadbeef_model", model[4], 32'hDEADBEEF);
    txn_a(1'b1, 32'h12, 32'h12345678);
    txn_a(1'b0, 32'h10, 32'h0);
    txn_a(1'b0, 32'h100, 32'h0);

    // Reset lands on the commit edge of a write: no ack, storage untouched.
    req_a = 1'b1; mw_a = 1'b1; adr_a = 32'h20; wd_a = 32'hCAFEF00D;
    step();
    step();
    reset = 1'b1;
    step();
    check("abort_ack", {31'h0, ack_a}, 32'h0);
    req_a = 1'b0;
    step();
    check("abort_ack2", {31'h0, ack_a}, 32'h0);
    reset = 1'b0;
    step();
    check("abort_ack3", {31'h0, ack_a}, 32'h0);
    txn_a(1'b0, 32'h20, 32'h0);

    for (int i = 0; i < 200; i++) txn_a(1'($urandom), rand_adr(), $urandom);

    // Zero-wait instance: seed word 4, then hold a read request for 8 cycles.
    req_b = 1'b1; mw_b = 1'b1; adr_b = 32'h10; wd_b = 32'hA5A5_1234;
    step();
    check("b_wr_ack", {31'h0, ack_b}, 32'h1);
    check("b_wr_rd", rd_b, 32'h0);
    check("b_wr_err", {31'h0, err_b}, 32'h0);
    req_b = 1'b0;
    step();
    check("b_wr_done", {31'h0, ack_b}, 32'h0);
    req_b = 1'b1; mw_b = 1'b0; adr_b = 32'h10;
    for (int i = 0; i < 8; i++) begin
      check("b_ack_pattern", {31'h0, ack_b}, 32'(i % 2));
      check("b_rd", rd_b, (i % 2 == 1) ? 32'hA5A5_1234 : 32'h0);
      step();
    end
    req_b = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bus_responder.md
DMEM_BUS_RESPONDER -- requirements
Module: dmem_bus_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, meaning idle cycles inserted between request acceptance and response (0..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 64, meaning number of 32-bit words of backing storage.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  1  initiator request, held high until ack.
REQ-007 memwrite  input  1  1 = write, 0 = read; qualified by req.
REQ-008 dataadr  input  32  byte address.
REQ-009 writedata  input  32  write data.
REQ-010 ack  output  1  one-cycle response strobe.
REQ-011 readdata  output  32  read data; valid only while ack=1.
REQ-012 err  output  1  error flag; valid only while ack=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: req=1 -> accept: capture memwrite, dataadr, writedata; go to WAIT if WAIT_STATES>0, else RESP.
REQ-015 WAIT: count WAIT_STATES cycles, then RESP; req, memwrite, dataadr and writedata are ignored in WAIT.
REQ-016 RESP: ack=1 for exactly one cycle, then IDLE unconditionally.
REQ-017 Latency: request accepted at edge N -> ack high in cycle N+1+WAIT_STATES.
REQ-018 req is ignored in RESP; req still high in the IDLE cycle after RESP is a new request.
REQ-019 Max throughput: one transaction per WAIT_STATES+2 cycles.
REQ-020 Error: err=1 with ack if captured dataadr[1:0]!=0 or dataadr[31:2]>=DEPTH_WORDS.
REQ-021 Word index = captured dataadr[31:2].
REQ-022 A valid write SHALL update storage at the edge entering RESP; an erroneous write SHALL leave storage unchanged.
REQ-023 A valid read SHALL drive the stored word on readdata during ack; an erroneous read SHALL drive 0.
REQ-024 readdata and err SHALL be 0 whenever ack=0.
REQ-025 A write's readdata SHALL be 0.
REQ-026 Reads SHALL return storage content including a write completed in any earlier transaction.

Reset
REQ-027 reset=1 at an edge -> state IDLE, wait counter 0, captured request cleared.
REQ-028 After reset: ack=0, err=0, readdata=0.
REQ-029 reset in WAIT or RESP SHALL abort the transaction: no ack, no storage update if reset coincides with the commit edge.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 reset SHALL take priority over req at the same edge.

Structure
REQ-032 A shared package mem_bus_pkg SHALL hold the FSM state enum, WORD_W=32 and the error-check helper function.
REQ-033 Storage SHALL be the sub-module word_ram (single port, synchronous write, combinational read, parameter DEPTH_WORDS).
REQ-034 The FSM, wait counter, capture registers and error decode SHALL reside in dmem_bus_responder.

Verification
REQ-035 WAIT_STATES=2: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> each ack 3 cycles after acceptance; read readdata=0xDEADBEEF, err=0.
REQ-036 Write 0x12345678 to 0x00000012 (misaligned) -> ack with err=1; subsequent read of 0x00000010 returns 0xDEADBEEF.
REQ-037 Read 0x00000100 (word 64, DEPTH_WORDS=64) -> ack with err=1, readdata=0x00000000.
REQ-038 Write 0xCAFEF00D to 0x00000020, reset asserted in the second WAIT cycle -> no ack; after reset, read 0x00000020 returns its prior value.
REQ-039 WAIT_STATES=0, req held high for 8 cycles of reads -> ack pattern 0,1,0,1,0,1,0,1.
REQ-040 dataadr changed from 0x10 to 0x14 during WAIT -> response reflects word 0x10.
